// File: rtl/cacheline_adapter_pkg.sv
// Shared types and geometry for the cache-line to burst-memory adapter.
package cacheline_adapter_pkg;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;

  localparam logic [31:0] LINE_MASK = ~32'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    DONE
  } adapter_state_t;

  // Byte address of the first byte of the line containing a
  function automatic logic [31:0] line_align(input logic [31:0] a);
    return a & LINE_MASK;
  endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Bus bundles for the adapter: the cache-facing line port and the memory-facing burst port.
interface dfp_if;
  import cacheline_adapter_pkg::*;

  logic [31:0]       addr;
  logic              read;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output addr, read, write, wdata, input rdata, resp);
  modport slave  (input addr, read, write, wdata, output rdata, resp);
endinterface

interface bmem_if;
  import cacheline_adapter_pkg::*;

  logic [31:0]       addr;
  logic              read;
  logic              write;
  logic [BEAT_W-1:0] wdata;
  logic              ready;
  logic [31:0]       raddr;
  logic [BEAT_W-1:0] rdata;
  logic              rvalid;

  modport master (output addr, read, write, wdata, input ready, raddr, rdata, rvalid);
  modport slave  (input addr, read, write, wdata, output ready, raddr, rdata, rvalid);
endinterface

// File: rtl/cacheline_adapter.sv
// Converts single-shot 256-bit line reads/writes into 4-beat 64-bit memory bursts.
// One transaction in flight; the line register is shared by read assembly and write serialisation.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  dfp_if.slave   dfp,
  bmem_if.master bmem
);

  adapter_state_t    state_q, state_d;
  logic [1:0]        cnt_q;
  logic [LINE_W-1:0] line_q;
  logic [31:0]       addr_q;
  logic              last_beat;

  assign last_beat = (cnt_q == 2'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (dfp.write || dfp.read) begin
            addr_q <= line_align(dfp.addr);
            cnt_q  <= '0;
          end
          if (dfp.write) line_q <= dfp.wdata;
        end
        RD_REQ:  cnt_q <= '0;
        // count wraps 3->0 on the final beat, which is also the state exit
        RD_DATA: begin
          if (bmem.rvalid) begin
            line_q[cnt_q*BEAT_W +: BEAT_W] <= bmem.rdata;
            cnt_q <= cnt_q + 2'd1;
          end
        end
        WR_DATA: if (bmem.ready) cnt_q <= cnt_q + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    bmem.addr  = '0;
    bmem.read  = 1'b0;
    bmem.write = 1'b0;
    bmem.wdata = '0;
    dfp.resp   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dfp.write)     state_d = WR_DATA;
        else if (dfp.read) state_d = RD_REQ;
      end
      RD_REQ: begin
        bmem.addr = addr_q;
        bmem.read = 1'b1;
        if (bmem.ready) state_d = RD_DATA;
      end
      RD_DATA: if (bmem.rvalid && last_beat) state_d = DONE;
      WR_DATA: begin
        bmem.addr  = addr_q;
        bmem.write = 1'b1;
        bmem.wdata = line_q[cnt_q*BEAT_W +: BEAT_W];
        if (bmem.ready && last_beat) state_d = DONE;
      end
      DONE: begin
        dfp.resp = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dfp.rdata = line_q;

  // Protocol guards: no simultaneous read+write, and returning beats must belong to our line
  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst)
    (state_q == IDLE) |-> !(dfp.read && dfp.write));
  a_raddr_match: assert property (@(posedge clk) disable iff (!rst)
    (state_q == RD_DATA && bmem.rvalid) |-> (bmem.raddr == addr_q));

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed scoreboard bench for cacheline_adapter: stimulus queues expectations, a negedge monitor checks them.
module tb_cacheline_adapter;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
  } cmd_t;

  typedef struct {
    bit           rd;
    logic [255:0] line;
  } resp_t;

  logic clk;
  logic rst;

  dfp_if  dfp ();
  bmem_if bmem ();

  cacheline_adapter dut (
    .clk  (clk),
    .rst  (rst),
    .dfp  (dfp),
    .bmem (bmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_err    = 0;
  int    n_resp   = 0;
  cmd_t  exp_cmd[$];
  resp_t exp_resp[$];
  cmd_t  mc;
  resp_t mr;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      if (bmem.read && bmem.write) begin
        n_checks++;
        n_err++;
        $display("FAIL bmem_rd_wr_both: read=%0b write=%0b expected one-hot", bmem.read, bmem.write);
      end
      if (bmem.read || bmem.write) begin
        if (exp_cmd.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_bmem_cmd: addr=%0h write=%0b expected none", bmem.addr, bmem.write);
        end else begin
          mc = exp_cmd[0];
          chk("bmem_kind", {255'b0, bmem.write}, {255'b0, mc.wr});
          chk("bmem_addr", {224'b0, bmem.addr}, {224'b0, mc.addr});
          if (mc.wr) chk("bmem_wdata", {192'b0, bmem.wdata}, {192'b0, mc.data});
          if (bmem.ready) void'(exp_cmd.pop_front());
        end
      end
      if (dfp.resp) begin
        n_resp++;
        if (exp_resp.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_dfp_resp: resp=1 expected 0");
        end else begin
          mr = exp_resp.pop_front();
          if (mr.rd) chk("dfp_rdata", dfp.rdata, mr.line);
        end
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_resp"},   {255'b0, dfp.resp},   256'd0);
    chk({tag, "_rdata"},  dfp.rdata,            256'd0);
    chk({tag, "_bread"},  {255'b0, bmem.read},  256'd0);
    chk({tag, "_bwrite"}, {255'b0, bmem.write}, 256'd0);
    chk({tag, "_baddr"},  {224'b0, bmem.addr},  256'd0);
    chk({tag, "_bwdata"}, {192'b0, bmem.wdata}, 256'd0);
  endtask

  task automatic rd_txn(input logic [31:0] a, input logic [255:0] line,
                        input int rdy_lo, input int gap, output int w);
    int          hi;
    int          k;
    logic [31:0] la;
    la = a & 32'hFFFF_FFE0;
    dfp.addr  = a;
    dfp.read  = 1'b1;
    dfp.write = 1'b0;
    exp_cmd.push_back(cmd_t'{wr: 1'b0, addr: la, data: 64'h0});
    exp_resp.push_back(resp_t'{rd: 1'b1, line: line});
    bmem.ready = 1'b0;
    w = 0;
    do begin step(); w++; end while (!bmem.read && w < 20);
    chk("rd_start", {255'b0, bmem.read}, 256'd1);
    hi = 1;
    repeat (rdy_lo) begin
      step();
      if (bmem.read) hi++;
    end
    bmem.ready = 1'b1;
    step();
    bmem.ready = 1'b0;
    chk("rd_held_cycles", hi, rdy_lo + 1);
    chk("rd_dropped", {255'b0, bmem.read}, 256'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) step();
      bmem.rvalid = 1'b1;
      bmem.rdata  = line[i*64 +: 64];
      bmem.raddr  = la;
      step();
      bmem.rvalid = 1'b0;
      bmem.rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    k = 0;
    while (!dfp.resp && k < 20) begin step(); k++; end
    chk("rd_resp", {255'b0, dfp.resp}, 256'd1);
    step();
    dfp.read = 1'b0;
  endtask

  task automatic wr_txn(input logic [31:0] a, input logic [255:0] line,
                        input int stall_beat, input int stall_n);
    int k;
    dfp.addr  = a;
    dfp.wdata = line;
    dfp.write = 1'b1;
    dfp.read  = 1'b0;
    for (int i = 0; i < 4; i++)
      exp_cmd.push_back(cmd_t'{wr: 1'b1, addr: a & 32'hFFFF_FFE0, data: line[i*64 +: 64]});
    exp_resp.push_back(resp_t'{rd: 1'b0, line: 256'd0});
    bmem.ready = 1'b0;
    k = 0;
    do begin step(); k++; end while (!bmem.write && k < 20);
    chk("wr_start", {255'b0, bmem.write}, 256'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == stall_beat) begin
        bmem.ready = 1'b0;
        repeat (stall_n) step();
      end
      bmem.ready = 1'b1;
      step();
    end
    bmem.ready = 1'b0;
    k = 0;
    while (!dfp.resp && k < 20) begin step(); k++; end
    chk("wr_resp", {255'b0, dfp.resp}, 256'd1);
    step();
    dfp.write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int r0;
    logic [255:0] l1, l2, l3, l4, l5, l6, l7, l8, l9;
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l2 = {64'hDEAD_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 64'h0000_0000_0000_BEEF};
    l3 = {64'hD1D1_0000_0000_0003, 64'hD1D1_0000_0000_0002, 64'hD1D1_0000_0000_0001, 64'hD1D1_0000_0000_0000};
    l4 = {64'hA0A0_0000_0000_0003, 64'hA0A0_0000_0000_0002, 64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    l5 = {64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001, 64'hFEDC_BA98_7654_3210};
    l6 = {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555, 64'h7777_7777_7777_7777, 64'h9999_9999_9999_9999};
    l7 = {64'h0707_0707_0707_0707, 64'h0606_0606_0606_0606, 64'h0505_0505_0505_0505, 64'h0404_0404_0404_0404};
    l8 = {64'h0100_0000_0000_0003, 64'h0100_0000_0000_0002, 64'h0100_0000_0000_0001, 64'h0100_0000_0000_0000};
    l9 = {64'h0120_0000_0000_0003, 64'h0120_0000_0000_0002, 64'h0120_0000_0000_0001, 64'h0120_0000_0000_0000};

    rst         = 1'b0;
    dfp.addr    = '0;
    dfp.read    = 1'b0;
    dfp.write   = 1'b0;
    dfp.wdata   = '0;
    bmem.ready  = 1'b0;
    bmem.raddr  = '0;
    bmem.rdata  = '0;
    bmem.rvalid = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // 1: basic read, ready high, back-to-back beats
    rd_txn(32'h0000_1240, l1, 0, 0, w);
    chk("t1_first_cmd_latency", w, 1);
    chk("t1_single_pulse", {255'b0, dfp.resp}, 256'd0);

    // 2: write with 2-cycle ready stall before beat 2
    wr_txn(32'h0000_0060, l2, 2, 2);

    // 3: dirty writeback immediately followed by refill
    r0 = n_resp;
    wr_txn(32'h0000_0080, l3, 4, 0);
    rd_txn(32'h0000_00A0, l4, 0, 0, w);
    chk("t3_no_idle_gap", w, 1);
    chk("t3_resp_pulses", n_resp - r0, 2);

    // 4: ready low 5 cycles, 3-cycle gaps between beats, low address bits ignored
    rd_txn(32'h0000_3FE7, l5, 5, 3, w);

    // 5: reset mid-burst after two beats, remaining beats arrive afterwards
    r0 = n_resp;
    dfp.addr  = 32'h0000_2000;
    dfp.read  = 1'b1;
    exp_cmd.push_back(cmd_t'{wr: 1'b0, addr: 32'h0000_2000, data: 64'h0});
    bmem.ready = 1'b1;
    step();
    step();
    bmem.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bmem.rvalid = 1'b1;
      bmem.rdata  = l6[i*64 +: 64];
      bmem.raddr  = 32'h0000_2000;
      step();
    end
    bmem.rdata = l6[128 +: 64];
    rst        = 1'b0;
    dfp.read   = 1'b0;
    step();
    rst        = 1'b1;
    bmem.rdata = l6[192 +: 64];
    step();
    bmem.rvalid = 1'b0;
    @(negedge clk);
    chk_idle("t5_after_reset");
    repeat (3) step();
    chk("t5_no_resp", n_resp - r0, 0);
    chk("t5_rdata_cleared", dfp.rdata, 256'd0);
    rd_txn(32'h0000_2000, l7, 0, 1, w);

    // 6: back-to-back reads with request held through the completion cycle
    r0 = n_resp;
    rd_txn(32'h0000_0100, l8, 0, 0, w);
    rd_txn(32'h0000_0120, l9, 1, 0, w);
    chk("t6_no_gap", w, 1);
    chk("t6_resp_pulses", n_resp - r0, 2);

    repeat (4) step();
    chk("cmd_queue_empty", exp_cmd.size(), 0);
    chk("resp_queue_empty", exp_resp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
